// File: rtl/burst_xfer_engine_pkg.sv
// Shared definitions for the burst transfer engine.
// Holds the default bus widths, the FSM state encoding, the source
// select encoding and a small grant-validity helper.
package burst_xfer_engine_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int SIZE_W_DEF = 3;

  typedef logic [1:0] state_t;

  // State encoding kept as plain constants so older tools and
  // waveform scripts can decode the raw value.
  localparam state_t IDLE = 2'd0;
  localparam state_t XFER = 2'd1;
  localparam state_t DONE = 2'd2;

  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  // True when exactly one of the two grants is asserted.
  function automatic logic grant_one_hot(input logic grant_a, input logic grant_b);
    return grant_a ^ grant_b;
  endfunction

endpackage

// File: rtl/burst_xfer_engine_if.sv
// Bus bundle between the arbiter/sources/sink and the burst engine.
// Signals:
//   start, respA, respB       arbiter start pulse and one-hot grant
//   sizeA, sizeB              requested beat counts
//   dataA, dataB              head beats of the two sources
//   out_ready                 sink ready
//   out_valid, out_data       output beat port
//   out_src                   latched source (0 = A, 1 = B)
//   popA, popB                head-consumed strobes back to the sources
//   busy, done                engine status / completion pulse to the arbiter
//   beat_cnt, err             accepted-beat count and sticky protocol error
// Modports: slave = engine view, master = environment view.
interface burst_xfer_engine_if
  import burst_xfer_engine_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SIZE_W = SIZE_W_DEF
) ();

  logic              start;
  logic              respA;
  logic              respB;
  logic [SIZE_W-1:0] sizeA;
  logic [SIZE_W-1:0] sizeB;
  logic [DATA_W-1:0] dataA;
  logic [DATA_W-1:0] dataB;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_src;
  logic              popA;
  logic              popB;
  logic              busy;
  logic              done;
  logic [SIZE_W-1:0] beat_cnt;
  logic              err;

  modport slave (
    input  start, respA, respB, sizeA, sizeB, dataA, dataB, out_ready,
    output out_valid, out_data, out_src, popA, popB, busy, done, beat_cnt, err
  );

  modport master (
    output start, respA, respB, sizeA, sizeB, dataA, dataB, out_ready,
    input  out_valid, out_data, out_src, popA, popB, busy, done, beat_cnt, err
  );

endinterface

// File: rtl/burst_xfer_engine_beat_counter.sv
// Beat bookkeeping for one burst.
// A load sets the remaining-beat down-counter to the granted size and
// clears the accepted-beat up-counter; each dec moves one beat from
// remaining to accepted.
// Ports:
//   clk, reset     clock, asynchronous active-low reset
//   load_i         start of a new burst
//   load_val_i     granted size
//   dec_i          one beat accepted this cycle
//   beat_cnt_o     beats accepted so far (held after the burst ends)
//   zero_o         no beats remain
//   last_o         exactly one beat remains
module burst_xfer_engine_beat_counter
  import burst_xfer_engine_pkg::*;
#(
  parameter int SIZE_W = SIZE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [SIZE_W-1:0] load_val_i,
  input  logic              dec_i,
  output logic [SIZE_W-1:0] beat_cnt_o,
  output logic              zero_o,
  output logic              last_o
);

  logic [SIZE_W-1:0] remaining_q, remaining_d;
  logic [SIZE_W-1:0] beat_cnt_q, beat_cnt_d;

  // Next-state for both counters; dec is ignored once remaining hits
  // zero so beat_cnt can never exceed the loaded size.
  always_comb begin
    remaining_d = remaining_q;
    beat_cnt_d  = beat_cnt_q;
    if (load_i) begin
      remaining_d = load_val_i;
      beat_cnt_d  = '0;
    end else if (dec_i && (remaining_q != '0)) begin
      remaining_d = remaining_q - SIZE_W'(1);
      beat_cnt_d  = beat_cnt_q + SIZE_W'(1);
    end else begin
      remaining_d = remaining_q;
      beat_cnt_d  = beat_cnt_q;
    end
  end

  // Counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining_q <= '0;
      beat_cnt_q  <= '0;
    end else begin
      remaining_q <= remaining_d;
      beat_cnt_q  <= beat_cnt_d;
    end
  end

  assign beat_cnt_o = beat_cnt_q;
  assign zero_o     = (remaining_q == '0);
  assign last_o     = (remaining_q == SIZE_W'(1));

endmodule

// File: rtl/burst_xfer_engine.sv
// Burst transfer engine sitting behind a two-requester arbiter.
// On a legal start it latches the granted source and size, streams that
// many beats from the source to the valid/ready output (popping the
// source on each accepted beat) and then pulses done for one cycle.
// Ports:
//   clk    system clock
//   reset  asynchronous active-low reset
//   bus    burst_xfer_engine_if.slave bundle (grant, sources, sink, status)
module burst_xfer_engine
  import burst_xfer_engine_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int SIZE_W = SIZE_W_DEF
) (
  input  logic                clk,
  input  logic                reset,
  burst_xfer_engine_if.slave  bus
);

  state_t            state_q, state_d;
  logic              src_q, src_d;
  logic              err_q, err_d;

  logic              grant_ok_s;
  logic [SIZE_W-1:0] grant_size_s;
  logic              accept_s;
  logic              load_s;
  logic              dec_s;
  logic              cnt_zero_s;
  logic              cnt_last_s;
  logic [SIZE_W-1:0] beat_cnt_s;
  logic [DATA_W-1:0] mux_data_s;

  assign grant_ok_s   = grant_one_hot(bus.respA, bus.respB);
  assign grant_size_s = bus.respB ? bus.sizeB : bus.sizeA;
  assign accept_s     = (state_q == XFER) && bus.out_ready;

  // FSM next-state, counter control and protocol-error detection.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    err_d   = err_q;
    load_s  = 1'b0;
    dec_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start && grant_ok_s) begin
          load_s  = 1'b1;
          src_d   = bus.respB ? SRC_B : SRC_A;
          state_d = (grant_size_s == '0) ? DONE : XFER;
        end else if (bus.start) begin
          err_d = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (bus.start) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        if (cnt_zero_s) begin
          // Unreachable in normal operation; never strand the engine.
          state_d = DONE;
        end else if (accept_s) begin
          dec_s   = 1'b1;
          state_d = cnt_last_s ? DONE : XFER;
        end else begin
          state_d = XFER;
        end
      end
      DONE: begin
        if (bus.start) begin
          err_d = 1'b1;
        end else begin
          err_d = err_q;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched source and sticky error registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      src_q   <= SRC_A;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      err_q   <= err_d;
    end
  end

  burst_xfer_engine_beat_counter #(
    .SIZE_W (SIZE_W)
  ) u_beat_counter (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load_s),
    .load_val_i (grant_size_s),
    .dec_i      (dec_s),
    .beat_cnt_o (beat_cnt_s),
    .zero_o     (cnt_zero_s),
    .last_o     (cnt_last_s)
  );

  // Output data follows the latched source combinationally.
  always_comb begin
    if (src_q == SRC_B) begin
      mux_data_s = bus.dataB;
    end else begin
      mux_data_s = bus.dataA;
    end
  end

  assign bus.out_valid = (state_q == XFER);
  assign bus.out_data  = mux_data_s;
  assign bus.out_src   = src_q;
  // Pops are combinational so the source advances on the accepting edge.
  assign bus.popA      = accept_s && (src_q == SRC_A);
  assign bus.popB      = accept_s && (src_q == SRC_B);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.beat_cnt  = beat_cnt_s;
  assign bus.err       = err_q;

endmodule
